glb_read_arbiter: RTL and testbench

- Shares the single global-buffer (GLB) read port between the NoC controllers: filter, ifmap and psum-in.
- Each controller presents a read request and address. The arbiter grants one owner at a time, using round-robin with a bounded burst length.
- It drives the GLB read port and returns a per-requester read-valid strobe one cycle after each issued read.
- It sits between the NoC controllers and the GLB SRAM, inside the PE-array top level.

---
 rtl/glb_read_arbiter_if.sv | 27 ++
 rtl/glb_read_arbiter.sv | 120 ++++++++++++
 tb/tb_glb_read_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/glb_read_arbiter_if.sv
// glb_read_arbiter_if: requester-side and GLB-side signals of the GLB read arbiter.
// The slave modport is the arbiter; master is the controllers/SRAM side.
interface glb_read_arbiter_if #(
   parameter int NUM_REQ    = 3,
   parameter int ADDR_WIDTH = 20,
   parameter int DATA_WIDTH = 16
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ-1:0]            gnt;
   logic                          glb_re;
   logic [ADDR_WIDTH-1:0]         glb_addr;
   logic [DATA_WIDTH-1:0]         glb_rdata;
   logic [DATA_WIDTH-1:0]         rdata;
   logic [NUM_REQ-1:0]            rvalid;
   logic                          busy;

   modport slave (
      input  req, req_addr, glb_rdata,
      output gnt, glb_re, glb_addr, rdata, rvalid, busy
   );

   modport master (
      output req, req_addr, glb_rdata,
      input  gnt, glb_re, glb_addr, rdata, rvalid, busy
   );
endinterface

// File: rtl/glb_read_arbiter.sv
// glb_read_arbiter: round-robin owner of the single GLB read port with a contention-only burst limit.
// Optional per-requester read/stall counters are built when GLB_ARB_PERF_CNT_EN is defined.
module glb_read_arbiter #(
   parameter int NUM_REQ     = 3,
   parameter int ADDR_WIDTH  = 20,
   parameter int DATA_WIDTH  = 16,
   parameter int MAX_BURST   = 8,
   parameter int BURST_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   glb_read_arbiter_if.slave        bus_io
`ifdef GLB_ARB_PERF_CNT_EN
   ,
   output logic [NUM_REQ*32-1:0]    grant_cnt_o,
   output logic [NUM_REQ*32-1:0]    stall_cnt_o
`endif
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [BURST_WIDTH-1:0] BURST_LAST = BURST_WIDTH'(MAX_BURST - 1);

   typedef enum logic {IDLE, OWN} state_t;

   state_t                 state_q, state_d;
   logic [NUM_REQ-1:0]     gnt_q, gnt_d, rvalid_q, issue_v;
   logic [BURST_WIDTH-1:0] burst_q, burst_d;
   logic [IW-1:0]          rr_q, rr_d, own;
   logic [ADDR_WIDTH-1:0]  addr_mux;
   logic                   issue, contend;

   // One-hot of the first requester in m strictly after last, wrapping so last itself comes last.
   function automatic logic [NUM_REQ-1:0] rr_pick(input logic [IW-1:0] last, input logic [NUM_REQ-1:0] m);
      int c;
      rr_pick = '0;
      for (int j = NUM_REQ; j >= 1; j--) begin
         c = (int'(last) + j) % NUM_REQ;
         if (m[c]) rr_pick = NUM_REQ'(1) << c;
      end
   endfunction

   assign issue_v = bus_io.req & gnt_q;
   assign issue   = |issue_v;
   assign contend = |(bus_io.req & ~gnt_q);

   always_comb begin
      own      = '0;
      addr_mux = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_q[i]) own = IW'(i);
         addr_mux |= bus_io.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{issue_v[i]}};
      end
   end

   always_comb begin
      gnt_d   = gnt_q;
      burst_d = burst_q;
      rr_d    = rr_q;
      if (state_q == IDLE) begin
         if (|bus_io.req) begin
            gnt_d   = rr_pick(rr_q, bus_io.req);
            burst_d = '0;
         end
      end else if (!issue) begin
         gnt_d   = rr_pick(own, bus_io.req);
         burst_d = '0;
         rr_d    = own;
      end else if (contend && burst_q == BURST_LAST) begin
         gnt_d   = rr_pick(own, bus_io.req & ~gnt_q);
         burst_d = '0;
         rr_d    = own;
      end else begin
         burst_d = (burst_q == BURST_LAST) ? burst_q : burst_q + 1'b1;
      end
      state_d = (|gnt_d) ? OWN : IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         burst_q  <= '0;
         rr_q     <= '0;
         rvalid_q <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         burst_q  <= burst_d;
         rr_q     <= rr_d;
         rvalid_q <= issue_v;
      end
   end

   assign bus_io.gnt      = gnt_q;
   assign bus_io.glb_re   = issue;
   assign bus_io.glb_addr = addr_mux;
   assign bus_io.rdata    = bus_io.glb_rdata;
   assign bus_io.rvalid   = rvalid_q;
   assign bus_io.busy     = |gnt_q;

`ifdef GLB_ARB_PERF_CNT_EN
   logic [NUM_REQ*32-1:0] grant_cnt_q, stall_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (issue_v[i]) grant_cnt_q[i*32 +: 32] <= grant_cnt_q[i*32 +: 32] + 32'd1;
            if (bus_io.req[i] && !gnt_q[i]) stall_cnt_q[i*32 +: 32] <= stall_cnt_q[i*32 +: 32] + 32'd1;
         end
      end
   end

   assign grant_cnt_o = grant_cnt_q;
   assign stall_cnt_o = stall_cnt_q;
`endif

   a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt_q));
endmodule

// File: tb/tb_glb_read_arbiter.sv
// tb_glb_read_arbiter: randomized and directed scoreboard bench for glb_read_arbiter.
module tb_glb_read_arbiter;
   localparam int N  = 3;
   localparam int AW = 20;
   localparam int DW = 16;
   localparam int MB = 8;

   logic clk = 0;
   logic reset = 0;
   always #5 clk = ~clk;

   glb_read_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
`ifdef GLB_ARB_PERF_CNT_EN
   logic [N*32-1:0] grant_cnt, stall_cnt;
`endif

   glb_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .BURST_WIDTH(4)) dut (
      .clk(clk),
      .reset(reset),
      .bus_io(bus)
`ifdef GLB_ARB_PERF_CNT_EN
      ,
      .grant_cnt_o(grant_cnt),
      .stall_cnt_o(stall_cnt)
`endif
   );

   typedef struct {
      int idx;
      int due;
      logic [DW-1:0] data;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int owner = -1, cnt = 0, rr = 0, last_issue = -1;
   int left[N];
   int ngr[N];
   int nst[N];
   logic [N-1:0] r;
   logic [AW-1:0] a[N];

   function automatic logic [DW-1:0] mem(input logic [AW-1:0] ad);
      return DW'(ad * 37 + (ad >> 5)) ^ 16'hc35a;
   endfunction

   function automatic int pick(input int start, input logic [N-1:0] m);
      for (int j = 0; j < N; j++)
         if (m[(start + j) % N]) return (start + j) % N;
      return -1;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // GLB SRAM: data for the address read last cycle
   always @(posedge clk) if (bus.glb_re === 1'b1) bus.glb_rdata <= mem(bus.glb_addr);

   always @(negedge clk) begin
      if (!reset) begin
         if (q.size() != 0 && q[0].due == cyc) begin
            check("rvalid", bus.rvalid, N'(1) << q[0].idx);
            check("rdata", bus.rdata, q[0].data);
            void'(q.pop_front());
         end else begin
            check("rvalid_idle", bus.rvalid, 0);
         end
      end
   end

   task automatic model_step();
      logic [N-1:0] others;
      if (owner < 0) begin
         if (r != 0) begin
            owner = pick(rr + 1, r);
            cnt = 0;
         end
      end else if (!r[owner]) begin
         rr = owner;
         owner = pick(owner + 1, r);
         cnt = 0;
      end else begin
         others = r;
         others[owner] = 1'b0;
         if (others != 0 && cnt == MB - 1) begin
            rr = owner;
            owner = pick(owner + 1, others);
            cnt = 0;
         end else if (cnt < MB - 1) begin
            cnt++;
         end
      end
   endtask

   task automatic tick();
      logic [N-1:0] eg;
      int iss;
      @(posedge clk);
      #1;
      bus.req = r;
      for (int i = 0; i < N; i++) bus.req_addr[i*AW +: AW] = a[i];
      #1;
      eg = (owner < 0) ? '0 : N'(1) << owner;
      iss = (owner >= 0 && r[owner]) ? owner : -1;
      check("gnt", bus.gnt, eg);
      check("glb_re", bus.glb_re, iss >= 0);
      check("glb_addr", bus.glb_addr, (iss >= 0) ? a[iss] : '0);
      check("busy", bus.busy, owner >= 0);
`ifdef GLB_ARB_PERF_CNT_EN
      for (int i = 0; i < N; i++) begin
         check("grant_cnt", grant_cnt[i*32 +: 32], ngr[i]);
         check("stall_cnt", stall_cnt[i*32 +: 32], nst[i]);
      end
`endif
      if (iss >= 0) q.push_back('{iss, cyc + 1, mem(a[iss])});
      for (int i = 0; i < N; i++)
         if (r[i]) begin
            if (eg[i]) ngr[i]++;
            else nst[i]++;
         end
      last_issue = iss;
      model_step();
   endtask

   task automatic agents(input bit rnd);
      for (int i = 0; i < N; i++) begin
         if (last_issue == i) begin
            left[i]--;
            a[i] = rnd ? AW'($urandom) : a[i] + 1'b1;
         end
         if (rnd && left[i] == 0 && $urandom_range(0, 3) == 0) begin
            left[i] = $urandom_range(1, 12);
            a[i] = AW'($urandom);
         end
         r[i] = (left[i] > 0);
      end
   endtask

   task automatic do_reset();
      #1 reset = 1;
      #1;
      check("rst_gnt", bus.gnt, 0);
      check("rst_rvalid", bus.rvalid, 0);
      check("rst_glb_re", bus.glb_re, 0);
      check("rst_busy", bus.busy, 0);
      r = '0;
      bus.req = '0;
      for (int i = 0; i < N; i++) begin
         left[i] = 0;
         ngr[i] = 0;
         nst[i] = 0;
      end
      q.delete();
      owner = -1;
      cnt = 0;
      rr = 0;
      last_issue = -1;
      @(posedge clk);
      #1 reset = 0;
   endtask

   task automatic contention(input int n);
      for (int i = 0; i < N; i++) begin
         left[i] = 100000;
         a[i] = AW'(i * 'h10000);
      end
      for (int k = 0; k < n; k++) begin
         agents(0);
         tick();
         if (k > 0) check("rr_order", bus.gnt, N'(1) << (((k - 1) / MB + 1) % N));
      end
   endtask

   initial begin
      int first_k, last_k, nis, last2, first0, n2;
      r = '0;
      bus.req = '0;
      bus.req_addr = '0;
      bus.glb_rdata = '0;
      for (int i = 0; i < N; i++) a[i] = '0;
      do_reset();

      first_k = -1;
      last_k = -1;
      nis = 0;
      left[0] = 20;
      a[0] = '0;
      for (int k = 0; k < 26; k++) begin
         agents(0);
         tick();
         if (last_issue == 0) begin
            if (first_k < 0) first_k = k;
            last_k = k;
            nis++;
         end
      end
      check("single_first", first_k, 1);
      check("single_span", last_k - first_k + 1, 20);
      check("single_reads", nis, 20);

      do_reset();
      contention(48);

      do_reset();
      left[2] = 3;
      left[0] = 5;
      a[2] = 20'h300;
      a[0] = 20'h100;
      last2 = -1;
      first0 = -1;
      n2 = 0;
      for (int k = 0; k < 14; k++) begin
         agents(0);
         tick();
         if (last_issue == 2) begin
            last2 = k;
            n2++;
         end
         if (last_issue == 0 && first0 < 0) first0 = k;
      end
      check("early_gap", first0 - last2, 2);
      check("early_reads2", n2, 3);

      do_reset();
      for (int i = 0; i < N; i++) left[i] = 100000;
      for (int k = 0; k < 5; k++) begin
         agents(0);
         tick();
      end
      do_reset();
      contention(20);

      do_reset();
      for (int k = 0; k < 800; k++) begin
         agents(1);
         tick();
      end
      for (int i = 0; i < N; i++) left[i] = 0;
      r = '0;
      repeat (4) tick();
      @(negedge clk);
      #1;
      check("drain", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
